// File: rtl/riscv_lsu_pkg.sv
// Shared encodings for the load/store unit: RISC-V funct3 access sizes, FSM states,
// and the legality check that both the FSM and the bench reason about.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, FAULT} lsu_state_t;

  // Illegal funct3 and misalignment share one fault path.
  function automatic logic lsu_bad(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      LDST_B, LDST_BU: lsu_bad = 1'b0;
      LDST_H, LDST_HU: lsu_bad = lo[0];
      LDST_W:          lsu_bad = |lo;
      default:         lsu_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Word-wide memory bus between the LSU (master) and the data memory (slave).
interface riscv_lsu_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport master (output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
                  input  mem_rd_i, mem_ready_i);
  modport slave  (input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
                  output mem_rd_i, mem_ready_i);
endinterface

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering: store enables/replication and load lane select with extension.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wd,
  input  logic [31:0] rd_word,
  output logic [3:0]  be,
  output logic [31:0] wd_lane,
  output logic [31:0] rd_ext
);

  logic [7:0]  rd_b;
  logic [15:0] rd_h;

  always_comb begin
    case (addr_lo)
      2'd0:    rd_b = rd_word[7:0];
      2'd1:    rd_b = rd_word[15:8];
      2'd2:    rd_b = rd_word[23:16];
      default: rd_b = rd_word[31:24];
    endcase
    rd_h = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    case (size)
      LDST_B:  rd_ext = {{24{rd_b[7]}}, rd_b};
      LDST_BU: rd_ext = {24'd0, rd_b};
      LDST_H:  rd_ext = {{16{rd_h[15]}}, rd_h};
      LDST_HU: rd_ext = {16'd0, rd_h};
      default: rd_ext = rd_word;
    endcase

    // Loads fetch the whole word; lane selection happens on the way back.
    be      = 4'hF;
    wd_lane = wd;
    if (we) begin
      case (size)
        LDST_B: begin
          be      = 4'b0001 << addr_lo;
          wd_lane = {4{wd[7:0]}};
        end
        LDST_H: begin
          be      = addr_lo[1] ? 4'b1100 : 4'b0011;
          wd_lane = {2{wd[15:0]}};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/riscv_lsu.sv
// Single-outstanding load/store unit: FSM, wait counter and request latches.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  riscv_lsu_if.master mem
);

  localparam logic [7:0] CNT_LAST = 8'(MAX_WAIT - 1);

  lsu_state_t  state;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [7:0]  cnt_q;
  logic        busy;
  logic [3:0]  be;
  logic [31:0] wd_lane;
  logic [31:0] rd_ext;

  riscv_lsu_align u_align (
    .we      (we_q),
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wd      (wd_q),
    .rd_word (mem.mem_rd_i),
    .be      (be),
    .wd_lane (wd_lane),
    .rd_ext  (rd_ext)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 3'd0;
      addr_q     <= 32'd0;
      wd_q       <= 32'd0;
      cnt_q      <= 8'd0;
      core_rd_o  <= 32'd0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      // Result and fault flags are one-cycle pulses unless re-set below.
      core_rd_o  <= 32'd0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          cnt_q <= 8'd0;
          if (core_req_i) begin
            if (lsu_bad(core_size_i, core_addr_i[1:0])) begin
              misalign_o <= 1'b1;
              state      <= FAULT;
            end else begin
              we_q   <= core_we_i;
              size_q <= core_size_i;
              addr_q <= core_addr_i;
              wd_q   <= core_wd_i;
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem.mem_ready_i) begin
            core_rd_o <= we_q ? 32'd0 : rd_ext;
            state     <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            bus_err_o <= 1'b1;
            state     <= FAULT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy           = (state == BUSY);
  assign core_stall_o   = (state == IDLE) ? core_req_i : busy;
  assign mem.mem_req_o  = busy;
  assign mem.mem_we_o   = busy & we_q;
  assign mem.mem_be_o   = busy ? be : 4'd0;
  assign mem.mem_addr_o = {addr_q[31:2], 2'b00};
  assign mem.mem_wd_o   = wd_lane;

endmodule
